// File: rtl/clock_time_setter.sv
// Time-setting front end for a BCD wall clock: debounced MODE/INC keys drive an edit FSM
// that captures the running time, lets the user step hours then minutes, and hands the result back.
module clock_time_setter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_MODE_N,
    input  logic       KEY_INC_N,
    input  logic [3:0] cur_hour_t,
    input  logic [3:0] cur_hour_u,
    input  logic [3:0] cur_min_t,
    input  logic [3:0] cur_min_u,
    output logic [3:0] set_hour_t,
    output logic [3:0] set_hour_u,
    output logic [3:0] set_min_t,
    output logic [3:0] set_min_u,
    output logic       load_valid,
    input  logic       load_ready,
    output logic       edit_hour,
    output logic       edit_min,
    output logic       blink,
    output logic [1:0] dbg_state_o
);

    // Handshake: the time on set_* transfers on a rising edge with load_valid && load_ready;
    // load_valid stays high and set_* stay frozen until that edge.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2,
        S_COMMIT   = 2'd3
    } state_t;

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BLW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_CYCLES - 1);

    // Key index 0 is MODE, index 1 is INC.
    logic [1:0]     sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];

    state_t         state_q, state_d;
    logic [3:0]     ht_q, hu_q, mt_q, mu_q, ht_d, hu_d, mt_d, mu_d;
    logic           blink_q, blink_d;
    logic [BLW-1:0] bl_cnt_q, bl_cnt_d;
    logic           hour_ok, min_ok, edit_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q   <= {KEY_INC_N, KEY_MODE_N};
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]     = db_q[k];
            db_cnt_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) db_d[k] = sync2_q[k];
                else                        db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
            end
        end
    end

    assign press = db_prev_q & ~db_q;

    assign hour_ok = ((cur_hour_t < 4'd2) && (cur_hour_u <= 4'd9)) ||
                     ((cur_hour_t == 4'd2) && (cur_hour_u <= 4'd3));
    assign min_ok  = (cur_min_t <= 4'd5) && (cur_min_u <= 4'd9);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            ht_q     <= '0;
            hu_q     <= '0;
            mt_q     <= '0;
            mu_q     <= '0;
            blink_q  <= 1'b0;
            bl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ht_q     <= ht_d;
            hu_q     <= hu_d;
            mt_q     <= mt_d;
            mu_q     <= mu_d;
            blink_q  <= blink_d;
            bl_cnt_q <= bl_cnt_d;
        end
    end

    // MODE is tested before INC in each edit state, so a simultaneous INC is dropped.
    always_comb begin
        state_d = state_q;
        ht_d    = ht_q;
        hu_d    = hu_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d = S_SET_HOUR;
                    ht_d    = hour_ok ? cur_hour_t : 4'd0;
                    hu_d    = hour_ok ? cur_hour_u : 4'd0;
                    mt_d    = min_ok  ? cur_min_t  : 4'd0;
                    mu_d    = min_ok  ? cur_min_u  : 4'd0;
                end
            end
            S_SET_HOUR: begin
                if (press[0]) begin
                    state_d = S_SET_MIN;
                end else if (press[1]) begin
                    if ((ht_q == 4'd2) && (hu_q == 4'd3)) begin
                        ht_d = 4'd0;
                        hu_d = 4'd0;
                    end else if (hu_q == 4'd9) begin
                        ht_d = ht_q + 4'd1;
                        hu_d = 4'd0;
                    end else begin
                        hu_d = hu_q + 4'd1;
                    end
                end
            end
            S_SET_MIN: begin
                if (press[0]) begin
                    state_d = S_COMMIT;
                end else if (press[1]) begin
                    if ((mt_q == 4'd5) && (mu_q == 4'd9)) begin
                        mt_d = 4'd0;
                        mu_d = 4'd0;
                    end else if (mu_q == 4'd9) begin
                        mt_d = mt_q + 4'd1;
                        mu_d = 4'd0;
                    end else begin
                        mu_d = mu_q + 4'd1;
                    end
                end
            end
            S_COMMIT: begin
                if (load_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Blink restarts high on every entry into an edit field so the new field is visible at once.
    assign edit_d = (state_d == S_SET_HOUR) || (state_d == S_SET_MIN);

    always_comb begin
        blink_d  = 1'b0;
        bl_cnt_d = '0;
        if (edit_d) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
            end else if (bl_cnt_q == BL_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_d  = blink_q;
                bl_cnt_d = bl_cnt_q + BLW'(1);
            end
        end
    end

    assign set_hour_t  = ht_q;
    assign set_hour_u  = hu_q;
    assign set_min_t   = mt_q;
    assign set_min_u   = mu_q;
    assign load_valid  = (state_q == S_COMMIT);
    assign edit_hour   = (state_q == S_SET_HOUR);
    assign edit_min    = (state_q == S_SET_MIN);
    assign blink       = blink_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/clock_time_setter.md
CLOCK_TIME_SETTER -- requirements
Module: clock_time_setter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles required to accept a key level change.
REQ-002 Parameter BLINK_CYCLES, default 12500000, is the half-period of the blink output, in clock cycles.
REQ-003 CLOCK_50  in  1  single system clock; all logic is clocked on the rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 KEY_MODE_N  in  1  raw pushbutton, active-low, asynchronous to the clock; advances the edit mode.
REQ-006 KEY_INC_N  in  1  raw pushbutton, active-low, asynchronous to the clock; increments the field being edited.
REQ-007 cur_hour_t, cur_hour_u, cur_min_t, cur_min_u  in  4 each  current running time as BCD digits.
REQ-008 set_hour_t, set_hour_u, set_min_t, set_min_u  out  4 each  edited time as BCD digits.
REQ-009 load_valid  out  1  the set_* outputs hold a time to be loaded by the clock.
REQ-010 load_ready  in  1  the clock accepts the load on this cycle.
REQ-011 edit_hour  out  1  the hour field is being edited.
REQ-012 edit_min  out  1  the minute field is being edited.
REQ-013 blink  out  1  display blink enable for the field being edited.

Function
REQ-014 Each key input SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-015 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; the debounce counter clears whenever the two levels are equal.
REQ-016 A debounced 1->0 transition SHALL generate a one-cycle press pulse; releases generate nothing.
REQ-017 The first effect of a press SHALL appear between DEBOUNCE_CYCLES and DEBOUNCE_CYCLES+4 cycles after the raw key settles low.
REQ-018 The FSM states SHALL be IDLE, SET_HOUR, SET_MIN and COMMIT; MODE presses move IDLE->SET_HOUR->SET_MIN->COMMIT.
REQ-019 On the IDLE->SET_HOUR transition, cur_* SHALL be captured into set_*.
REQ-020 During that capture, a captured hour >23 or any non-BCD hour digit SHALL load hour 00; a captured minute >59 or any non-BCD minute digit SHALL load minute 00.
REQ-021 In SET_HOUR, an INC press SHALL increment the hour in BCD: units 9->0 with a carry into tens, and 23->00.
REQ-022 In SET_MIN, an INC press SHALL increment the minute in BCD: units 9->0 with a carry into tens, and 59->00.
REQ-023 An INC press SHALL be ignored in IDLE and COMMIT; an INC press SHALL never alter the field that is not being edited.
REQ-024 If MODE and INC presses occur on the same cycle, MODE SHALL take effect and INC SHALL be dropped.
REQ-025 In COMMIT, load_valid SHALL be 1 and set_* SHALL be held stable; all key presses are ignored.
REQ-026 The transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1; on the next cycle load_valid=0 and the state is IDLE.
REQ-027 With load_ready tied high, load_valid SHALL be a one-cycle pulse.
REQ-028 load_valid SHALL be 0 in every state other than COMMIT.
REQ-029 edit_hour SHALL be 1 only in SET_HOUR; edit_min SHALL be 1 only in SET_MIN.
REQ-030 On entry to SET_HOUR or SET_MIN, blink SHALL be set to 1 and the blink counter cleared; blink then toggles every BLINK_CYCLES cycles.
REQ-031 blink SHALL be 0 in IDLE and COMMIT.
REQ-032 set_* SHALL retain the last edited value in IDLE until the next capture.

Reset
REQ-033 When RESET_N=0, the block SHALL immediately, without a clock edge, force: state IDLE, set_*=0, load_valid=0, edit_hour=0, edit_min=0, blink=0, debounced levels=1 (released), all counters=0.
REQ-034 Reset asserted mid-edit or mid-COMMIT SHALL abandon the operation; no load occurs.
REQ-035 After RESET_N deasserts, the first press SHALL be honoured only after full debounce, even if the key was held during reset.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
REQ-036 Reset pulse during activity -> all outputs 0 asynchronously; state IDLE.
REQ-037 cur=12:34, MODE, then INC x12 -> edit_hour=1 and set=12:34, then 00:34 (23->00 wrap exercised).
REQ-038 Continuing: MODE, INC x24 -> set_min 58, then 00 (34+24=58, +2 wraps); MODE with load_ready=0 for 5 cycles -> load_valid=1 with set_* stable; raise ready -> load_valid=0 next cycle, IDLE, set=00:00 retained.
REQ-039 KEY_INC_N toggled every 2 cycles for 20 cycles then held low in SET_MIN -> exactly one increment.
REQ-040 cur=29:75, MODE -> set=00:00; simultaneous MODE+INC press in SET_HOUR -> state SET_MIN, hour unchanged.
REQ-041 RESET_N low while in COMMIT with load_ready=0 -> load_valid falls with no clock edge; no transfer observed.
